// File: rtl/uart_cmd_host.sv
// -----------------------------------------------------------------------------
// uart_cmd_host
//
// Host-side command initiator for the UART RAM-loader protocol.
// Takes one command at a time from a local controller, serialises the opcode
// and its payload into a uart_tx byte port, and for read commands collects
// the response bytes arriving on a uart_rx byte port.
//
// Opcodes: CPU_RST 0x2a, CPU_RUN 0x2b, CONF_WR 0x2c, CONF_RD 0x2d,
//          DATA_WR 0x2e, DATA_RD 0x2f. Anything else is rejected with err_o.
//
// Ports
//   clk_i, rst_n_i          clock, asynchronous active-low reset
//   cmd_i/cmd_vld_i/cmd_rdy_o
//                           command handshake; conf_w0_i, conf_w1_i,
//                           wr_len_i and rsp_len_i are sampled at accept
//   wr_data_i/_vld_i/_rdy_o DATA_WR payload byte stream
//   uart_tx_data_o/_vld_o/_rdy_i
//                           registered byte stream towards uart_tx
//   uart_rx_data_i/_vld_i/_rdy_o
//                           byte stream from uart_rx (never stalled)
//   rsp_data_o/rsp_data_vld_o  response bytes, one-cycle pulse each
//   done_o                  one-cycle pulse at command completion
//   timeout_o               pulse with done_o when the response stalled
//   err_o                   pulse with done_o on an unknown opcode
//
// XLEN must be at least 32: the two configuration words are sent as
// four bytes each.
// -----------------------------------------------------------------------------
module uart_cmd_host #(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [7:0]      cmd_i,
  input  logic            cmd_vld_i,
  output logic            cmd_rdy_o,
  input  logic [XLEN-1:0] conf_w0_i,
  input  logic [XLEN-1:0] conf_w1_i,
  input  logic [XLEN-1:0] wr_len_i,
  input  logic [XLEN-1:0] rsp_len_i,
  input  logic [7:0]      wr_data_i,
  input  logic            wr_data_vld_i,
  output logic            wr_data_rdy_o,
  output logic [7:0]      uart_tx_data_o,
  output logic            uart_tx_data_vld_o,
  input  logic            uart_tx_data_rdy_i,
  input  logic [7:0]      uart_rx_data_i,
  input  logic            uart_rx_data_vld_i,
  output logic            uart_rx_data_rdy_o,
  output logic [7:0]      rsp_data_o,
  output logic            rsp_data_vld_o,
  output logic            done_o,
  output logic            timeout_o,
  output logic            err_o
);

  localparam logic [7:0] OP_CPU_RST = 8'h2a;
  localparam logic [7:0] OP_CPU_RUN = 8'h2b;
  localparam logic [7:0] OP_CONF_WR = 8'h2c;
  localparam logic [7:0] OP_CONF_RD = 8'h2d;
  localparam logic [7:0] OP_DATA_WR = 8'h2e;
  localparam logic [7:0] OP_DATA_RD = 8'h2f;

  // Idle-counter terminal value; the counter sits at 0 on the first idle
  // cycle after a byte, so TIMEOUT_CYC idle cycles elapse before expiry.
  localparam logic [XLEN-1:0] IDLE_MAX = XLEN'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPC,
    S_CONF,
    S_DATA,
    S_RECV,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  // Command context latched at accept
  logic [7:0]      r_opc;
  logic [63:0]     r_conf;
  logic [XLEN-1:0] r_rem;
  logic [2:0]      r_idx;
  logic [XLEN-1:0] r_idle;

  // Output registers
  logic [7:0]      r_tx_data;
  logic            r_tx_vld;
  logic            r_cmd_rdy;
  logic            r_rx_rdy;
  logic [7:0]      r_rsp_data;
  logic            r_rsp_vld;
  logic            r_done;
  logic            r_timeout;
  logic            r_err;

  // Decoded events
  logic            w_accept;
  logic            w_opc_ok;
  logic            w_tx_xfer;
  logic            w_rx_take;
  logic            w_rem_last;
  logic            w_idle_exp;

  // Output-process results
  logic            w_tx_load;
  logic [7:0]      w_tx_byte;
  logic            w_wr_rdy;
  logic            w_timeout;

  // r_cmd_rdy is only ever set while the FSM is (about to be) idle
  assign w_accept   = (r_state == S_IDLE) & r_cmd_rdy & cmd_vld_i;
  assign w_opc_ok   = (cmd_i >= OP_CPU_RST) && (cmd_i <= OP_DATA_RD);
  assign w_tx_xfer  = r_tx_vld & uart_tx_data_rdy_i;
  // rx bytes are only consumed into the response stream while in RECV;
  // everywhere else they are accepted and dropped.
  assign w_rx_take  = (r_state == S_RECV) & uart_rx_data_vld_i;
  assign w_rem_last = (r_rem == XLEN'(1));
  assign w_idle_exp = (r_idle == IDLE_MAX);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept && w_opc_ok) w_state_nxt = S_OPC;
      end
      S_OPC: begin
        if (w_tx_xfer) begin
          unique case (r_opc)
            OP_CONF_WR: w_state_nxt = S_CONF;
            OP_DATA_WR: w_state_nxt = (r_rem != '0) ? S_DATA : S_DONE;
            OP_CONF_RD,
            OP_DATA_RD: w_state_nxt = (r_rem != '0) ? S_RECV : S_DONE;
            default:    w_state_nxt = S_DONE;
          endcase
        end
      end
      S_CONF: begin
        if (w_tx_xfer && (r_idx == 3'd7)) w_state_nxt = S_DONE;
      end
      S_DATA: begin
        if (w_tx_xfer && w_rem_last) w_state_nxt = S_DONE;
      end
      S_RECV: begin
        // Either the last byte or the idle expiry ends the response
        if ((w_rx_take && w_rem_last) || w_idle_exp) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (next values for the tx holding register and flags)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_tx_load = 1'b0;
    w_tx_byte = r_tx_data;
    w_wr_rdy  = 1'b0;
    w_timeout = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept && w_opc_ok) begin
          w_tx_load = 1'b1;
          w_tx_byte = cmd_i;
        end
      end
      S_CONF: begin
        // Reload only once the previous byte left: gives the one-cycle
        // bubble between bytes.
        if (!r_tx_vld) begin
          w_tx_load = 1'b1;
          w_tx_byte = r_conf[{r_idx, 3'b000} +: 8];
        end
      end
      S_DATA: begin
        w_wr_rdy = ~r_tx_vld;
        if (wr_data_vld_i && !r_tx_vld) begin
          w_tx_load = 1'b1;
          w_tx_byte = wr_data_i;
        end
      end
      S_RECV: begin
        // A last byte landing on the expiry cycle completes normally
        w_timeout = w_idle_exp & ~(w_rx_take & w_rem_last);
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_opc      <= '0;
      r_conf     <= '0;
      r_rem      <= '0;
      r_idx      <= '0;
      r_idle     <= '0;
      r_tx_data  <= '0;
      r_tx_vld   <= 1'b0;
      r_cmd_rdy  <= 1'b0;
      r_rx_rdy   <= 1'b0;
      r_rsp_data <= '0;
      r_rsp_vld  <= 1'b0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_rx_rdy  <= 1'b1;
      r_cmd_rdy <= (w_state_nxt == S_IDLE);

      if (w_accept) begin
        r_opc  <= cmd_i;
        r_conf <= {conf_w1_i[31:0], conf_w0_i[31:0]};
        r_rem  <= (cmd_i == OP_DATA_WR) ? wr_len_i : rsp_len_i;
        r_idx  <= '0;
      end else begin
        if ((r_state == S_CONF) && w_tx_xfer) r_idx <= r_idx + 3'd1;
        // Only decremented while at least one byte remains, so never wraps
        if (((r_state == S_DATA) && w_tx_xfer) || w_rx_take)
          r_rem <= r_rem - XLEN'(1);
      end

      // Idle counter runs only inside RECV and restarts on every byte
      if ((r_state != S_RECV) || w_rx_take) r_idle <= '0;
      else                                   r_idle <= r_idle + XLEN'(1);

      if (w_tx_load) begin
        r_tx_data <= w_tx_byte;
        r_tx_vld  <= 1'b1;
      end else if (w_tx_xfer) begin
        r_tx_vld  <= 1'b0;
      end

      r_rsp_vld <= w_rx_take;
      if (w_rx_take) r_rsp_data <= uart_rx_data_i;

      r_done    <= (w_state_nxt == S_DONE) | (w_accept & ~w_opc_ok);
      r_err     <= w_accept & ~w_opc_ok;
      r_timeout <= w_timeout;
    end
  end

  assign cmd_rdy_o          = r_cmd_rdy;
  assign wr_data_rdy_o      = w_wr_rdy;
  assign uart_tx_data_o     = r_tx_data;
  assign uart_tx_data_vld_o = r_tx_vld;
  assign uart_rx_data_rdy_o = r_rx_rdy;
  assign rsp_data_o         = r_rsp_data;
  assign rsp_data_vld_o     = r_rsp_vld;
  assign done_o             = r_done;
  assign timeout_o          = r_timeout;
  assign err_o              = r_err;

endmodule

// File: tb/tb_uart_cmd_host.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_host: self-checking bench for uart_cmd_host.
// A table of commands with hand-derived expected counts, a randomized loop
// checked against a frame-level reference model, and hand sequences for
// reset, latency, timeout and error corner cases.
// -----------------------------------------------------------------------------
module tb_uart_cmd_host;
  localparam int XLEN = 32;
  localparam int TO   = 100;
  localparam logic [7:0] OP_RST = 8'h2a, OP_RUN = 8'h2b, OP_CWR = 8'h2c;
  localparam logic [7:0] OP_CRD = 8'h2d, OP_DWR = 8'h2e, OP_DRD = 8'h2f;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] cmd = '0;
  logic cmd_vld = 1'b0, cmd_rdy;
  logic [XLEN-1:0] w0 = '0, w1 = '0, wl = '0, rl = '0;
  logic [7:0] wd = '0;
  logic wd_vld = 1'b0, wd_rdy;
  logic [7:0] tx_d;
  logic tx_vld, tx_rdy = 1'b1;
  logic [7:0] rx_d = '0;
  logic rx_vld = 1'b0, rx_rdy;
  logic [7:0] rsp_d;
  logic rsp_vld, done, tmo, err;

  always #5 clk = ~clk;

  uart_cmd_host #(.XLEN(XLEN), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .cmd_i(cmd), .cmd_vld_i(cmd_vld), .cmd_rdy_o(cmd_rdy),
    .conf_w0_i(w0), .conf_w1_i(w1), .wr_len_i(wl), .rsp_len_i(rl),
    .wr_data_i(wd), .wr_data_vld_i(wd_vld), .wr_data_rdy_o(wd_rdy),
    .uart_tx_data_o(tx_d), .uart_tx_data_vld_o(tx_vld), .uart_tx_data_rdy_i(tx_rdy),
    .uart_rx_data_i(rx_d), .uart_rx_data_vld_i(rx_vld), .uart_rx_data_rdy_o(rx_rdy),
    .rsp_data_o(rsp_d), .rsp_data_vld_o(rsp_vld),
    .done_o(done), .timeout_o(tmo), .err_o(err)
  );

  int n_chk = 0, n_fail = 0;
  logic [7:0] img [64];
  bit stall_en = 1'b0;

  // ---------------- monitor: observed transfers and pulses ----------------
  logic [7:0] q_tx[$], q_rsp[$];
  int acc_cnt = 0, done_cnt = 0, to_cnt = 0, err_cnt = 0, proto_err = 0;
  int wd_taken = 0, mcyc = 0, last_rsp = 0, last_done = 0;
  logic p_vld = 1'b0, p_rdy = 1'b0;
  logic [7:0] p_d = '0;

  always @(posedge clk) begin
    mcyc <= mcyc + 1;
    if (!rst_n) begin
      p_vld <= 1'b0;
    end else begin
      if (tx_vld && tx_rdy) q_tx.push_back(tx_d);
      if (cmd_vld && cmd_rdy) acc_cnt <= acc_cnt + 1;
      if (wd_vld && wd_rdy) wd_taken <= wd_taken + 1;
      if (rsp_vld) begin q_rsp.push_back(rsp_d); last_rsp <= mcyc; end
      if (done) begin done_cnt <= done_cnt + 1; last_done <= mcyc; end
      if (done && tmo) to_cnt <= to_cnt + 1;
      if (done && err) err_cnt <= err_cnt + 1;
      // protocol rules: flags only with done, no payload take while holding
      // a byte, tx byte held stable while stalled
      if (((tmo || err) && !done) || (wd_rdy && tx_vld) ||
          (p_vld && !p_rdy && (!tx_vld || tx_d != p_d)))
        proto_err <= proto_err + 1;
      p_vld <= tx_vld; p_rdy <= tx_rdy; p_d <= tx_d;
    end
  end

  task automatic tick();
    @(negedge clk);
    tx_rdy = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] rxb(input int k);
    return 8'(8'haa + 17 * k);   // aa bb cc dd ee ...
  endfunction

  // Issue one command, feed payload / response, compare against the model.
  task automatic run_cmd(input logic [7:0] op, input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] lw, input logic [31:0] lr, input int nrx,
                         input bit stl, output int ntx, output int nrsp,
                         output int nto, output int ner);
    int tb0, rb0, d0, t0, e0, p0, k0, a_0, sent, gap, budget;
    logic [7:0] exp_tx[$], exp_rsp[$];
    bit ok, rd;
    // reference model: the frame the protocol defines for this command
    ok = (op >= OP_RST) && (op <= OP_DRD);
    rd = (op == OP_CRD) || (op == OP_DRD);
    exp_tx = {}; exp_rsp = {};
    if (ok) begin
      exp_tx.push_back(op);
      if (op == OP_CWR) begin
        for (int i = 0; i < 4; i++) exp_tx.push_back(a0[8*i +: 8]);
        for (int i = 0; i < 4; i++) exp_tx.push_back(a1[8*i +: 8]);
      end
      if (op == OP_DWR) for (int i = 0; i < int'(lw); i++) exp_tx.push_back(img[i]);
      if (rd) for (int i = 0; i < nrx && i < int'(lr); i++) exp_rsp.push_back(rxb(i));
    end
    tb0 = q_tx.size(); rb0 = q_rsp.size(); d0 = done_cnt; t0 = to_cnt;
    e0 = err_cnt; p0 = proto_err; k0 = wd_taken; a_0 = acc_cnt;
    stall_en = stl;
    cmd = op; w0 = a0; w1 = a1; wl = lw; rl = lr; cmd_vld = 1'b1;
    budget = 0;
    while (acc_cnt == a_0 && budget < 50) begin tick(); budget++; end
    cmd_vld = 1'b0;
    chk("accept", acc_cnt - a_0, 1);
    sent = 0; gap = $urandom_range(0, 3); budget = 0;
    while (done_cnt == d0 && budget < 3000) begin
      if (op == OP_DWR && wd_taken - k0 < int'(lw)) begin
        wd = img[wd_taken - k0];
        wd_vld = ($urandom_range(0, 2) != 0);
      end else wd_vld = 1'b0;
      rx_vld = 1'b0;
      if (rd && q_tx.size() > tb0 && sent < nrx) begin
        if (gap == 0) begin
          rx_vld = 1'b1; rx_d = rxb(sent); sent++; gap = $urandom_range(0, 3);
        end else gap--;
      end
      tick(); budget++;
    end
    wd_vld = 1'b0; rx_vld = 1'b0;
    repeat (3) tick();
    ntx = q_tx.size() - tb0; nrsp = q_rsp.size() - rb0;
    nto = to_cnt - t0; ner = err_cnt - e0;
    chk($sformatf("done_count op%02h", op), done_cnt - d0, 1);
    chk($sformatf("tx_len op%02h", op), ntx, exp_tx.size());
    for (int i = 0; i < ntx && i < exp_tx.size(); i++)
      chk($sformatf("tx_byte%0d op%02h", i, op), q_tx[tb0 + i], exp_tx[i]);
    chk($sformatf("rsp_len op%02h", op), nrsp, exp_rsp.size());
    for (int i = 0; i < nrsp && i < exp_rsp.size(); i++)
      chk($sformatf("rsp_byte%0d", i), q_rsp[rb0 + i], exp_rsp[i]);
    chk($sformatf("timeout op%02h", op), nto, (ok && rd && lr != 0 && nrx < int'(lr)));
    chk($sformatf("err op%02h", op), ner, !ok);
    chk($sformatf("protocol op%02h", op), proto_err - p0, 0);
  endtask

  typedef struct {
    logic [7:0] op; logic [31:0] a0, a1, lw, lr; int nrx; bit stl;
    int e_ntx, e_nrsp, e_to, e_err;
  } vec_t;
  vec_t vt[$];

  task automatic add(input logic [7:0] op, input logic [31:0] a0, input logic [31:0] a1,
                     input logic [31:0] lw, input logic [31:0] lr, input int nrx, input bit stl,
                     input int e_ntx, input int e_nrsp, input int e_to, input int e_err);
    vec_t v;
    v.op = op; v.a0 = a0; v.a1 = a1; v.lw = lw; v.lr = lr; v.nrx = nrx; v.stl = stl;
    v.e_ntx = e_ntx; v.e_nrsp = e_nrsp; v.e_to = e_to; v.e_err = e_err;
    vt.push_back(v);
  endtask

  initial begin
    int ntx, nrsp, nto, ner, b, r0, d0, tb0;
    logic [7:0] op;
    for (int i = 0; i < 64; i++) img[i] = 8'(i * 37 + 5);

    //    op      w0            w1            wlen rlen nrx stl  ntx nrsp to err
    add(OP_RST, 32'h0,        32'h0,        0,   0,   0,  0,   1,  0,   0, 0);
    add(OP_RUN, 32'h0,        32'h0,        0,   0,   0,  1,   1,  0,   0, 0);
    add(OP_CWR, 32'h00000158, 32'h00000023, 0,   0,   0,  1,   9,  0,   0, 0);
    add(OP_DWR, 32'h0,        32'h0,        36,  0,   0,  1,   37, 0,   0, 0);
    add(OP_DWR, 32'h0,        32'h0,        0,   0,   0,  0,   1,  0,   0, 0);
    add(OP_DRD, 32'h0,        32'h0,        0,   4,   4,  0,   1,  4,   0, 0);
    add(OP_DRD, 32'h0,        32'h0,        0,   4,   2,  0,   1,  2,   1, 0);
    add(8'h30,  32'h0,        32'h0,        0,   0,   0,  0,   0,  0,   0, 1);
    add(8'h29,  32'h0,        32'h0,        0,   0,   0,  0,   0,  0,   0, 1);
    add(OP_CRD, 32'h0,        32'h0,        0,   0,   0,  0,   1,  0,   0, 0);
    add(OP_CRD, 32'h0,        32'h0,        0,   8,   8,  1,   1,  8,   0, 0);

    // ---- reset values ----
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst cmd_rdy", cmd_rdy, 0);
    chk("rst tx", {tx_vld, tx_d}, 0);
    chk("rst rx_rdy", rx_rdy, 0);
    chk("rst wd_rdy", wd_rdy, 0);
    chk("rst rsp", {rsp_vld, rsp_d}, 0);
    chk("rst pulses", {done, tmo, err}, 0);
    rst_n = 1'b1;
    tick();
    chk("post-rst cmd_rdy", cmd_rdy, 1);
    chk("post-rst rx_rdy", rx_rdy, 1);

    // ---- CPU_RST latency, tx ready tied high ----
    stall_en = 1'b0;
    cmd = OP_RST; cmd_vld = 1'b1;
    tick(); cmd_vld = 1'b0;
    chk("rst-cmd opcode out", {tx_vld, tx_d}, {1'b1, OP_RST});
    chk("rst-cmd busy", cmd_rdy, 0);
    tick();
    chk("rst-cmd done after xfer", {done, err, tmo, tx_vld}, 4'b1000);
    tick();
    chk("rst-cmd pulse width", done, 0);
    chk("rst-cmd ready again", cmd_rdy, 1);

    // ---- unknown opcode: err/done next cycle, nothing sent ----
    tb0 = q_tx.size();
    cmd = 8'h30; cmd_vld = 1'b1;
    tick(); cmd_vld = 1'b0;
    chk("bad-op pulses", {err, done, tx_vld}, 3'b110);
    tick();
    chk("bad-op pulse width", {err, done}, 2'b00);
    chk("bad-op no tx", q_tx.size() - tb0, 0);

    // ---- table ----
    foreach (vt[i]) begin
      run_cmd(vt[i].op, vt[i].a0, vt[i].a1, vt[i].lw, vt[i].lr, vt[i].nrx, vt[i].stl,
              ntx, nrsp, nto, ner);
      chk($sformatf("vec%0d ntx", i), ntx, vt[i].e_ntx);
      chk($sformatf("vec%0d nrsp", i), nrsp, vt[i].e_nrsp);
      chk($sformatf("vec%0d timeout", i), nto, vt[i].e_to);
      chk($sformatf("vec%0d err", i), ner, vt[i].e_err);
      // timeout lands TIMEOUT_CYC cycles after the last delivered byte;
      // a completed read ends together with its last byte
      if (vt[i].e_to != 0)
        chk($sformatf("vec%0d timeout delay", i), last_done - last_rsp, TO);
      else if (vt[i].e_nrsp != 0)
        chk($sformatf("vec%0d done with last byte", i), last_done - last_rsp, 0);
    end

    // ---- stray rx byte in IDLE ----
    r0 = q_rsp.size(); d0 = done_cnt;
    rx_d = 8'h55; rx_vld = 1'b1;
    tick(); rx_vld = 1'b0;
    repeat (2) tick();
    chk("stray rx no rsp", q_rsp.size() - r0, 0);
    chk("stray rx no done", done_cnt - d0, 0);

    // ---- randomized commands against the model ----
    for (int it = 0; it < 25; it++) begin
      b = $urandom_range(0, 7);
      op = (b < 6) ? 8'(8'h2a + b) : 8'($urandom());
      wl = $urandom_range(0, 40);
      rl = $urandom_range(0, 6);
      run_cmd(op, $urandom(), $urandom(), wl, rl, $urandom_range(0, int'(rl)),
              1'($urandom_range(0, 1)), ntx, nrsp, nto, ner);
    end

    // ---- reset during the 3rd CONF byte ----
    stall_en = 1'b0;
    tb0 = q_tx.size();
    cmd = OP_CWR; w0 = 32'h04030201; w1 = 32'h08070605; cmd_vld = 1'b1;
    tick(); cmd_vld = 1'b0;
    b = 0;
    while (!(tx_vld && q_tx.size() - tb0 == 3) && b < 100) begin tick(); b++; end
    chk("3rd conf byte presented", {tx_vld, tx_d}, {1'b1, 8'h03});
    tx_rdy = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async vld drop", tx_vld, 0);
    chk("reset cmd_rdy low", cmd_rdy, 0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk("after reset cmd_rdy", cmd_rdy, 1);
    chk("after reset tx idle", tx_vld, 0);
    run_cmd(OP_RUN, 32'h0, 32'h0, 0, 0, 0, 0, ntx, nrsp, nto, ner);
    chk("cpu_run after reset ntx", ntx, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
